tiny_cpu_core: RTL

Parametrised successor of the original 8-bit LED-demo CPU. A single-issue, one-instruction-per-enabled-cycle accumulator/register machine. It has:
- a writable program ROM,
- a 16-entry register file with configurable data width,
- two-operand ALU ops, immediate load, conditional/unconditional jumps, an explicit OUT port and HALT.

It sits between the top-level clock divider (which supplies `ce` as a slow-tick enable) and the RGB LED driver, which consumes `out_data[2:0]`.

---
 rtl/tiny_cpu_core.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tiny_cpu_core.sv
// Accumulator/register CPU for the LED demo: writable program ROM, 16-entry register file,
// one instruction retired per enabled clock while running.
module tiny_cpu_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              run,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [15:0]       prog_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              busy
);

  localparam int unsigned ROM_D = 1 << PC_W;
  localparam int unsigned NREG  = 16;

  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALTED
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       rom  [ROM_D];
  logic [DATA_W-1:0] regs [NREG];

  logic [15:0]       instr;
  logic [3:0]        opcode, rd, rs;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rd_val, rs_val;

  logic [PC_W-1:0]   pc_d;
  logic [DATA_W-1:0] out_data_d, wr_data;
  logic              out_valid_d, wr_en;

  // Combinational fetch/decode; R0 is hard-wired to zero on read
  assign instr  = rom[pc];
  assign opcode = instr[15:12];
  assign rd     = instr[11:8];
  assign rs     = instr[7:4];
  assign imm8   = instr[7:0];
  assign rd_val = (rd == 4'd0) ? '0 : regs[rd];
  assign rs_val = (rs == 4'd0) ? '0 : regs[rs];

  // Next-state, next-pc and execute
  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    out_data_d  = out_data;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_data     = rd_val;
    case (state_q)
      S_LOAD: begin
        if (run) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_LOAD;
        end else if (ce) begin
          pc_d = pc + PC_W'(1);
          case (opcode)
            OP_INC: begin wr_en = 1'b1; wr_data = rd_val + DATA_W'(1); end
            OP_ADD: begin wr_en = 1'b1; wr_data = rd_val + rs_val; end
            OP_SUB: begin wr_en = 1'b1; wr_data = rd_val - rs_val; end
            OP_AND: begin wr_en = 1'b1; wr_data = rd_val & rs_val; end
            OP_OR:  begin wr_en = 1'b1; wr_data = rd_val | rs_val; end
            OP_XOR: begin wr_en = 1'b1; wr_data = rd_val ^ rs_val; end
            OP_SHL: begin wr_en = 1'b1; wr_data = rd_val << 1; end
            OP_SHR: begin wr_en = 1'b1; wr_data = rd_val >> 1; end
            OP_LDI: begin wr_en = 1'b1; wr_data = DATA_W'(imm8); end
            OP_JNZ: begin
              if (rd_val != '0) pc_d = imm8[PC_W-1:0];
            end
            OP_JMP: pc_d = imm8[PC_W-1:0];
            OP_OUT: begin
              out_data_d  = rd_val;
              out_valid_d = 1'b1;
            end
            OP_HALT: begin
              pc_d    = pc;
              state_d = S_HALTED;
            end
            default: ;
          endcase
        end
      end
      S_HALTED: begin
        if (!run) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, pc, register file and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      pc        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      halted    <= (state_d == S_HALTED);
      busy      <= (state_d == S_RUN);
      if (wr_en && (rd != 4'd0)) regs[rd] <= wr_data;
    end
  end

  // Program ROM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (rst_n && prog_we && (state_q == S_LOAD)) rom[prog_addr] <= prog_data;
  end

endmodule
